mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clock  in  1  single clock; all state changes on its rising edge.
REQ-002 nReset  in  1  reset, asynchronous assert, active-low.
REQ-003 EXE_out  in  EXE_out_t  registered EXE stage bundle: rs2[31:0], rd[4:0], result[31:0], Wmem, Rmem, Wreg, func3[2:0].
REQ-004 dmem_req  out  1  data-memory request; held high until dmem_gnt.
REQ-005 dmem_we  out  1  1 = store, 0 = load.
REQ-006 dmem_addr  out  32  word-aligned address: result with [1:0] forced to 0.
REQ-007 dmem_be  out  4  byte enables.
REQ-008 dmem_wdata  out  32  lane-aligned store data.
REQ-009 dmem_gnt  in  1  request accepted this cycle.
REQ-010 dmem_rvalid  in  1  load data valid; arrives no earlier than the cycle after gnt.
REQ-011 dmem_rdata  in  32  load word.
REQ-012 stall  out  1  freeze all upstream stages and hold EXE_out.
REQ-013 misalign  out  1  one-cycle pulse flagging a misaligned access.
REQ-014 MEM_out  out  MEM_out_t  registered writeback bundle: rd[4:0], wdata[31:0], Wreg.

Function
REQ-015 States: IDLE, REQ, WAIT.
REQ-016 Non-memory op (Rmem=Wmem=0): stall=0; MEM_out <= {rd, result, Wreg} at the next edge (latency 1).
REQ-017 Alignment: half (func3[1:0]=01) requires addr[0]=0; word (10) requires addr[1:0]=0; byte is always aligned.
REQ-018 Misaligned memory op: no request, stall=0, misalign=1 for that cycle, MEM_out.Wreg <= 0.
REQ-019 Wmem and Rmem both set: the op is treated as a store.
REQ-020 Store byte enables: SB = 4'b0001 << addr[1:0]; SH = addr[1] ? 1100 : 0011; SW = 1111.
REQ-021 Store data: SB replicates rs2[7:0] x4; SH replicates rs2[15:0] x2; SW passes rs2.
REQ-022 IDLE with an aligned op: dmem_req=1 combinationally. Stay in IDLE if gnt and store; go to WAIT if gnt and load; otherwise go to REQ.
REQ-023 REQ: dmem_req=1 with addr, we, be and wdata stable. On gnt, go to IDLE (store) or WAIT (load).
REQ-024 WAIT: dmem_req=0. On rvalid, go to IDLE and capture load data into MEM_out.
REQ-025 stall=1 while an aligned op is pending. stall=0 in the completion cycle (store gnt, or rvalid in WAIT), so upstream advances on that edge.
REQ-026 Load extraction by func3: LB 000 sign-extends the selected byte; LH 001 sign-extends the selected half; LW 010 takes the word; LBU 100 and LHU 101 zero-extend. Byte select is addr[1:0]; half select is addr[1].
REQ-027 Store completion: MEM_out.Wreg <= 0. Load completion: MEM_out <= {rd, extracted, Wreg}.
REQ-028 While stall=1, MEM_out.Wreg <= 0 every edge (bubble). rd and wdata are don't-care.
REQ-029 rvalid outside WAIT is ignored.
REQ-030 func3 values 011, 110 and 111 on a memory op: treated as word.

Reset
REQ-031 nReset low: state=IDLE and MEM_out cleared to all zeros, asynchronously.
REQ-032 nReset low: dmem_req, stall and misalign are 0.
REQ-033 A reset during REQ or WAIT abandons the access; a late rvalid after reset is ignored per REQ-029.

Structure
REQ-034 core_types_pkg holds: MEM_out_t; mem_state_t enum; func3 localparams LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-035 Sub-module mem_align (combinational) computes be, wdata, load extraction and misalign; mem_stage holds the FSM and the MEM_out register.

Verification
REQ-036 ALU op: result=0x1234, rd=5, Wreg=1 -> MEM_out={5, 0x1234, 1} after 1 edge; stall never 1.
REQ-037 SB: rs2=0xAB, addr=0x103, gnt same cycle -> be=1000, wdata=0xABABABAB; stall=0; Wreg bubble.
REQ-038 LB: addr=0x101, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x00008000 -> stall=1 for 5 cycles, MEM_out.wdata=0xFFFFFF80. Repeat as LBU -> 0x00000080.
REQ-039 LW at addr=0x102 -> misalign pulses once, dmem_req stays 0, Wreg=0, no stall.
REQ-040 Load in WAIT, nReset pulsed, then rvalid -> state IDLE, MEM_out zero, rvalid ignored, next op proceeds normally.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared pipeline bundle types, memory FSM states and func3 encodings
// used by the memory stage and its alignment helper.
package core_types_pkg;

  typedef struct packed {
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
    logic [2:0]  func3;
  } EXE_out_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        Wreg;
  } MEM_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, sign/zero extension for loads and
// access alignment check. Purely combinational.
module mem_align
  import core_types_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  func3_i,
  input  logic        mem_op_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [31:0] shifted;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // func3 codes 011/110/111 fall into the word bucket via func3[1]
  assign is_b = (func3_i[1:0] == 2'b00);
  assign is_h = (func3_i[1:0] == 2'b01);
  assign is_w = func3_i[1];

  assign shifted = rdata_i >> {addr_i, 3'b000};
  assign bsel    = shifted[7:0];
  assign hsel    = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  assign misalign_o = mem_op_i &
                      ((is_h & addr_i[0]) | (is_w & (|addr_i)));

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rs2_i;
    rdata_o = rdata_i;
    unique case (1'b1)
      is_b: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{rs2_i[7:0]}};
        rdata_o = func3_i[2] ? {24'd0, bsel}
                             : {{24{bsel[7]}}, bsel};
      end
      is_h: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{rs2_i[15:0]}};
        rdata_o = func3_i[2] ? {16'd0, hsel}
                             : {{16{hsel[15]}}, hsel};
      end
      is_w: begin
        be_o    = 4'b1111;
        wdata_o = rs2_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: data-memory request/grant/rvalid FSM,
// upstream stall generation and the registered writeback bundle.
module mem_stage
  import core_types_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  EXE_out_t    EXE_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misalign,
  output MEM_out_t    MEM_out
);

  mem_state_t  state_q;
  MEM_out_t    mem_q;
  MEM_out_t    mem_d;
  logic        mem_op;
  logic        is_st;
  logic        mis;
  logic        op_ok;
  logic        req_raw;
  logic        stall_raw;
  logic [31:0] ld_data;

  assign mem_op = EXE_out.Wmem | EXE_out.Rmem;
  assign is_st  = EXE_out.Wmem;
  assign op_ok  = mem_op & ~mis;

  mem_align u_align (
    .addr_i     (EXE_out.result[1:0]),
    .func3_i    (EXE_out.func3),
    .mem_op_i   (mem_op),
    .rs2_i      (EXE_out.rs2),
    .rdata_i    (dmem_rdata),
    .be_o       (dmem_be),
    .wdata_o    (dmem_wdata),
    .rdata_o    (ld_data),
    .misalign_o (mis)
  );

  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_raw   = op_ok;
        stall_raw = op_ok & ~(dmem_gnt & is_st);
      end
      REQ: begin
        req_raw   = 1'b1;
        stall_raw = ~(dmem_gnt & is_st);
      end
      WAIT: stall_raw = ~dmem_rvalid;
      default: ;
    endcase
  end

  // Reset holds the handshake outputs low even though IDLE decodes them
  assign dmem_req  = nReset & req_raw;
  assign stall     = nReset & stall_raw;
  assign misalign  = nReset & (state_q == IDLE) & mis;
  assign dmem_we   = is_st;
  assign dmem_addr = {EXE_out.result[31:2], 2'b00};
  assign MEM_out   = mem_q;

  always_comb begin
    mem_d = '{rd: EXE_out.rd, wdata: EXE_out.result, Wreg: 1'b0};
    if (state_q == IDLE && !mem_op)
      mem_d.Wreg = EXE_out.Wreg;
    if (state_q == WAIT && dmem_rvalid) begin
      mem_d.wdata = ld_data;
      mem_d.Wreg  = EXE_out.Wreg;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      mem_q   <= '0;
    end else begin
      mem_q <= mem_d;
      unique case (state_q)
        IDLE:
          if (op_ok)
            state_q <= dmem_gnt ? (is_st ? IDLE : WAIT) : REQ;
        REQ:
          if (dmem_gnt)
            state_q <= is_st ? IDLE : WAIT;
        WAIT:
          if (dmem_rvalid)
            state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage with a writeback scoreboard
// plus hand-written reset and handshake corner sequences.
module tb_mem_stage;
  import core_types_pkg::*;

  logic        clk;
  logic        nReset;
  EXE_out_t    EXE_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        misalign;
  MEM_out_t    MEM_out;

  int checks = 0;
  int errors = 0;

  MEM_out_t sb_q[$];

  typedef struct {
    EXE_out_t    exe;
    int          gdel;
    int          rdel;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    int          stall_n;
    logic        mis;
    MEM_out_t    exp;
  } vec_t;

  vec_t vecs[15];

  mem_stage dut (
    .Clock       (clk),
    .nReset      (nReset),
    .EXE_out     (EXE_out),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall       (stall),
    .misalign    (misalign),
    .MEM_out     (MEM_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  function automatic EXE_out_t mk(
    logic [31:0] rs2, logic [4:0] rd, logic [31:0] res,
    logic w, logic r, logic wreg, logic [2:0] f3);
    EXE_out_t e;
    e.rs2 = rs2; e.rd = rd; e.result = res;
    e.Wmem = w; e.Rmem = r; e.Wreg = wreg; e.func3 = f3;
    return e;
  endfunction

  function automatic vec_t mkv(
    EXE_out_t e, int g, int r, logic [31:0] rd,
    logic [3:0] be, logic [31:0] wd, int sn, logic mis,
    logic [4:0] xrd, logic [31:0] xwd, logic xw);
    vec_t v;
    v.exe = e; v.gdel = g; v.rdel = r; v.rdata = rd;
    v.be = be; v.wd = wd; v.stall_n = sn; v.mis = mis;
    v.exp.rd = xrd; v.exp.wdata = xwd; v.exp.Wreg = xw;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int stalls;
    int reqs;
    int miss;
    int xreq;
    bit done;
    bit first;
    bit isld;
    MEM_out_t e;
    @(posedge clk); #1;
    EXE_out = v.exe;
    dmem_rdata = v.rdata;
    sb_q.push_back(v.exp);
    isld = !v.exe.Wmem && v.exe.Rmem && !v.mis;
    stalls = 0; reqs = 0; miss = 0; done = 0; first = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      dmem_gnt = (v.exe.Wmem | v.exe.Rmem) && !v.mis && k == v.gdel;
      dmem_rvalid = isld && k == v.gdel + v.rdel;
      #4;
      if (dmem_req) begin
        reqs++;
        if (first) begin
          first = 0;
          chk({nm, " addr"}, 64'(dmem_addr),
              64'({v.exe.result[31:2], 2'b00}));
          chk({nm, " we"}, 64'(dmem_we), 64'(v.exe.Wmem));
          if (v.exe.Wmem) begin
            chk({nm, " be"}, 64'(dmem_be), 64'(v.be));
            chk({nm, " wdata"}, 64'(dmem_wdata), 64'(v.wd));
          end
        end
      end
      if (misalign) miss++;
      if (stall) stalls++;
      else done = 1;
    end
    if (!done) chk({nm, " timeout"}, 64'd1, 64'd0);
    @(posedge clk); #1;
    dmem_gnt = 0; dmem_rvalid = 0; EXE_out = '0;
    #4;
    if (sb_q.size() == 0) begin
      chk({nm, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      if (e.Wreg) chk({nm, " mem_out"}, 64'(MEM_out), 64'(e));
      else chk({nm, " wreg"}, 64'(MEM_out.Wreg), 64'd0);
    end
    xreq = ((v.exe.Wmem | v.exe.Rmem) && !v.mis) ? v.gdel + 1 : 0;
    chk({nm, " stalls"}, 64'(stalls), 64'(v.stall_n));
    chk({nm, " reqs"}, 64'(reqs), 64'(xreq));
    chk({nm, " mis"}, 64'(miss), 64'(v.mis));
  endtask

  initial begin
    vecs[0]  = mkv(mk(0, 5, 32'h1234, 0, 0, 1, 3'b000),
                   0, 0, 0, 0, 0, 0, 0, 5, 32'h1234, 1);
    vecs[1]  = mkv(mk(32'hAB, 1, 32'h103, 1, 0, 0, SB),
                   0, 0, 0, 4'b1000, 32'hABABABAB, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(mk(0, 7, 32'h101, 0, 1, 1, LB),
                   2, 3, 32'h00008000, 0, 0, 5, 0, 7, 32'hFFFFFF80, 1);
    vecs[3]  = mkv(mk(0, 7, 32'h101, 0, 1, 1, LBU),
                   2, 3, 32'h00008000, 0, 0, 5, 0, 7, 32'h00000080, 1);
    vecs[4]  = mkv(mk(0, 4, 32'h102, 0, 1, 1, LW),
                   0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mkv(mk(32'h1234ABCD, 2, 32'h102, 1, 0, 1, SH),
                   1, 0, 0, 4'b1100, 32'hABCDABCD, 1, 0, 0, 0, 0);
    vecs[6]  = mkv(mk(32'hDEADBEEF, 2, 32'h200, 1, 0, 0, SW),
                   0, 0, 0, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(mk(0, 8, 32'h202, 0, 1, 1, LH),
                   0, 1, 32'h80011234, 0, 0, 1, 0, 8, 32'hFFFF8001, 1);
    vecs[8]  = mkv(mk(0, 8, 32'h202, 0, 1, 1, LHU),
                   0, 1, 32'h80011234, 0, 0, 1, 0, 8, 32'h00008001, 1);
    vecs[9]  = mkv(mk(0, 9, 32'h300, 0, 1, 1, LW),
                   1, 2, 32'hCAFEF00D, 0, 0, 3, 0, 9, 32'hCAFEF00D, 1);
    vecs[10] = mkv(mk(0, 10, 32'h103, 0, 1, 1, LB),
                   0, 1, 32'h7F000000, 0, 0, 1, 0, 10, 32'h0000007F, 1);
    vecs[11] = mkv(mk(32'h1, 2, 32'h101, 1, 0, 0, SH),
                   0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[12] = mkv(mk(32'h11223344, 6, 32'h10, 1, 1, 1, SW),
                   0, 0, 0, 4'b1111, 32'h11223344, 0, 0, 0, 0, 0);
    vecs[13] = mkv(mk(0, 11, 32'h20, 0, 1, 1, 3'b011),
                   0, 1, 32'h12345678, 0, 0, 1, 0, 11, 32'h12345678, 1);
    vecs[14] = mkv(mk(0, 12, 32'h22, 0, 1, 1, 3'b110),
                   0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    nReset = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    EXE_out = mk(0, 3, 32'h40, 0, 1, 1, LW);
    #12;
    chk("rst mem_out", 64'(MEM_out), 64'd0);
    chk("rst req", 64'(dmem_req), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst misalign", 64'(misalign), 64'd0);
    EXE_out = '0;
    nReset = 1;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i], $sformatf("v%0d", i));

    // Reset while a load waits for rvalid, then a stale rvalid
    @(posedge clk); #1;
    EXE_out = mk(0, 9, 32'h40, 0, 1, 1, LW);
    dmem_rdata = 32'hFFFFFFFF;
    dmem_gnt = 1;
    #4;
    chk("wrst stall0", 64'(stall), 64'd1);
    @(posedge clk); #1;
    dmem_gnt = 0;
    #1;
    chk("wrst wait_req", 64'(dmem_req), 64'd0);
    chk("wrst wait_stall", 64'(stall), 64'd1);
    nReset = 0;
    #1;
    chk("wrst mem_out", 64'(MEM_out), 64'd0);
    chk("wrst stall", 64'(stall), 64'd0);
    chk("wrst req", 64'(dmem_req), 64'd0);
    EXE_out = mk(0, 3, 32'h55, 0, 0, 1, 3'b000);
    @(posedge clk); #1;
    nReset = 1;
    dmem_rvalid = 1;
    #4;
    chk("wrst late_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    EXE_out = '0;
    #4;
    chk("wrst late_rvalid", 64'(MEM_out),
        64'({5'd3, 32'h55, 1'b1}));
    run_op(vecs[2], "post_rst");

    // rvalid during REQ must not complete the load
    @(posedge clk); #1;
    EXE_out = mk(0, 13, 32'h80, 0, 1, 1, LW);
    dmem_rdata = 32'h0BADF00D;
    #4;
    chk("rq stall0", 64'(stall), 64'd1);
    @(posedge clk); #1;
    dmem_rvalid = 1;
    #4;
    chk("rq stall1", 64'(stall), 64'd1);
    chk("rq req1", 64'(dmem_req), 64'd1);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    dmem_gnt = 1;
    #4;
    chk("rq wreg", 64'(MEM_out.Wreg), 64'd0);
    @(posedge clk); #1;
    dmem_gnt = 0;
    dmem_rvalid = 1;
    #4;
    chk("rq done", 64'(stall), 64'd0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    EXE_out = '0;
    #4;
    chk("rq mem_out", 64'(MEM_out),
        64'({5'd13, 32'h0BADF00D, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
